// File: rtl/hilo_pipe.sv
// hilo_pipe
//   Holds the architectural HI/LO registers and carries each EX-stage HI/LO
//   write through the EX/MEM and MEM/WB latches, committing at write-back.
//   The MEM and WB views are merged per half with everything older, so EX can
//   forward by picking "MEM, else WB, else register" as whole words.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   stall_i[2:0] stall vector (bit0 EX, bit1 MEM, bit2 WB), monotonic
//   flush_i      drops uncommitted requests; the WB request still commits
//   ex_whi_i     EX writes HI
//   ex_wlo_i     EX writes LO
//   ex_hi_i      HI write data from EX
//   ex_lo_i      LO write data from EX
//   mem_whilo_o  MEM latch holds a HI or LO write
//   mem_hi_o     HI as seen after the MEM request
//   mem_lo_o     LO as seen after the MEM request
//   wb_whilo_o   WB latch holds a HI or LO write
//   wb_hi_o      HI as seen after the WB request
//   wb_lo_o      LO as seen after the WB request
//   hi_o         architectural HI
//   lo_o         architectural LO

module hilo_pipe #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    stall_i,
    input  logic          flush_i,
    input  logic          ex_whi_i,
    input  logic          ex_wlo_i,
    input  logic [DW-1:0] ex_hi_i,
    input  logic [DW-1:0] ex_lo_i,
    output logic          mem_whilo_o,
    output logic [DW-1:0] mem_hi_o,
    output logic [DW-1:0] mem_lo_o,
    output logic          wb_whilo_o,
    output logic [DW-1:0] wb_hi_o,
    output logic [DW-1:0] wb_lo_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic          r_m_whi;
    logic          r_m_wlo;
    logic [DW-1:0] r_m_hi;
    logic [DW-1:0] r_m_lo;
    logic          r_w_whi;
    logic          r_w_wlo;
    logic [DW-1:0] r_w_hi;
    logic [DW-1:0] r_w_lo;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    logic          w_commit;
    logic [DW-1:0] w_wb_hi;
    logic [DW-1:0] w_wb_lo;

    // The WB instruction has already retired when a flush arrives, so its
    // write goes through on the flush edge as well.
    assign w_commit = !stall_i[2] || flush_i;

    // EX/MEM latch
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_m_whi <= 1'b0;
            r_m_wlo <= 1'b0;
            r_m_hi  <= '0;
            r_m_lo  <= '0;
        end else if (stall_i[1]) begin
            r_m_whi <= r_m_whi;
            r_m_wlo <= r_m_wlo;
            r_m_hi  <= r_m_hi;
            r_m_lo  <= r_m_lo;
        end else if (stall_i[0]) begin
            r_m_whi <= 1'b0;
            r_m_wlo <= 1'b0;
            r_m_hi  <= '0;
            r_m_lo  <= '0;
        end else begin
            r_m_whi <= ex_whi_i;
            r_m_wlo <= ex_wlo_i;
            r_m_hi  <= ex_hi_i;
            r_m_lo  <= ex_lo_i;
        end
    end

    // MEM/WB latch
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_w_whi <= 1'b0;
            r_w_wlo <= 1'b0;
            r_w_hi  <= '0;
            r_w_lo  <= '0;
        end else if (stall_i[2]) begin
            r_w_whi <= r_w_whi;
            r_w_wlo <= r_w_wlo;
            r_w_hi  <= r_w_hi;
            r_w_lo  <= r_w_lo;
        end else if (stall_i[1]) begin
            r_w_whi <= 1'b0;
            r_w_wlo <= 1'b0;
            r_w_hi  <= '0;
            r_w_lo  <= '0;
        end else begin
            r_w_whi <= r_m_whi;
            r_w_wlo <= r_m_wlo;
            r_w_hi  <= r_m_hi;
            r_w_lo  <= r_m_lo;
        end
    end

    // Architectural registers; a disabled half is never touched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (r_w_whi) r_hi <= r_w_hi;
            if (r_w_wlo) r_lo <= r_w_lo;
        end
    end

    // Per-half merge: each view layers its own enabled half over the older view.
    assign w_wb_hi = r_w_whi ? r_w_hi : r_hi;
    assign w_wb_lo = r_w_wlo ? r_w_lo : r_lo;

    assign wb_hi_o     = w_wb_hi;
    assign wb_lo_o     = w_wb_lo;
    assign mem_hi_o    = r_m_whi ? r_m_hi : w_wb_hi;
    assign mem_lo_o    = r_m_wlo ? r_m_lo : w_wb_lo;
    assign mem_whilo_o = r_m_whi | r_m_wlo;
    assign wb_whilo_o  = r_w_whi | r_w_wlo;
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;

    // A stalled later stage must stall every earlier one.
    a_stall_monotonic : assert property (@(posedge clk) disable iff (rst)
        !(stall_i[2] && !stall_i[1]) && !(stall_i[1] && !stall_i[0]))
        else $error("stall_i not monotonic: %b", stall_i);

endmodule

// File: tb/tb_hilo_pipe.sv
module tb_hilo_pipe;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    stall_i;
    logic          flush_i;
    logic          ex_whi_i;
    logic          ex_wlo_i;
    logic [DW-1:0] ex_hi_i;
    logic [DW-1:0] ex_lo_i;
    logic          mem_whilo_o;
    logic [DW-1:0] mem_hi_o;
    logic [DW-1:0] mem_lo_o;
    logic          wb_whilo_o;
    logic [DW-1:0] wb_hi_o;
    logic [DW-1:0] wb_lo_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_pipe #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ex_whi_i    (ex_whi_i),
        .ex_wlo_i    (ex_wlo_i),
        .ex_hi_i     (ex_hi_i),
        .ex_lo_i     (ex_lo_i),
        .mem_whilo_o (mem_whilo_o),
        .mem_hi_o    (mem_hi_o),
        .mem_lo_o    (mem_lo_o),
        .wb_whilo_o  (wb_whilo_o),
        .wb_hi_o     (wb_hi_o),
        .wb_lo_o     (wb_lo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance to 1 time unit after the next rising edge: the start of a new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i  = 3'b000;
        flush_i  = 1'b0;
        ex_whi_i = 1'b0;
        ex_wlo_i = 1'b0;
        ex_hi_i  = '0;
        ex_lo_i  = '0;
    endtask

    task automatic ex_req(input logic whi, input logic wlo,
                          input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        ex_whi_i = whi;
        ex_wlo_i = wlo;
        ex_hi_i  = hi;
        ex_lo_i  = lo;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi_o, 32'h0); end
        n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want %h", lo_o, 32'h0); end
        n_checks++; if (mem_whilo_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_whilo: got %b want 0", mem_whilo_o); end
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_whilo: got %b want 0", wb_whilo_o); end
        n_checks++; if ({mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o} !== 128'h0) begin n_fail++; $display("FAIL reset_fwd: got %h %h %h %h want all 0", mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o); end
    endtask

    task automatic test_single_mthi();
        do_reset();
        ex_req(1'b1, 1'b0, 32'h12345678, 32'h0);        // cycle 0
        tick(); idle();                                 // cycle 1
        n_checks++; if (mem_whilo_o !== 1'b1) begin n_fail++; $display("FAIL single_mem_whilo: got %b want 1", mem_whilo_o); end
        n_checks++; if (mem_hi_o !== 32'h12345678) begin n_fail++; $display("FAIL single_mem_hi: got %h want %h", mem_hi_o, 32'h12345678); end
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL single_wb_whilo_c1: got %b want 0", wb_whilo_o); end
        n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL single_lo_c1: got %h want 0", lo_o); end
        tick();                                         // cycle 2
        n_checks++; if (wb_whilo_o !== 1'b1) begin n_fail++; $display("FAIL single_wb_whilo_c2: got %b want 1", wb_whilo_o); end
        n_checks++; if (wb_hi_o !== 32'h12345678) begin n_fail++; $display("FAIL single_wb_hi: got %h want %h", wb_hi_o, 32'h12345678); end
        n_checks++; if (mem_whilo_o !== 1'b0) begin n_fail++; $display("FAIL single_mem_whilo_c2: got %b want 0", mem_whilo_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL single_hi_c2: got %h want 0", hi_o); end
        tick();                                         // cycle 3
        n_checks++; if (hi_o !== 32'h12345678) begin n_fail++; $display("FAIL single_hi_c3: got %h want %h", hi_o, 32'h12345678); end
        n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL single_lo_c3: got %h want 0", lo_o); end
    endtask

    task automatic test_merge();
        do_reset();
        ex_req(1'b0, 1'b1, 32'h0, 32'hAAAA0000);
        tick(); idle(); tick(); tick();                 // LO = AAAA0000 committed
        n_checks++; if (lo_o !== 32'hAAAA0000) begin n_fail++; $display("FAIL merge_setup_lo: got %h want %h", lo_o, 32'hAAAA0000); end
        ex_req(1'b0, 1'b1, 32'h0, 32'h5);               // cycle 0: MTLO 5
        tick();
        ex_req(1'b1, 1'b0, 32'h7, 32'h0);               // cycle 1: MTHI 7
        tick(); idle();                                 // cycle 2
        n_checks++; if (mem_hi_o !== 32'h7) begin n_fail++; $display("FAIL merge_mem_hi: got %h want %h", mem_hi_o, 32'h7); end
        n_checks++; if (mem_lo_o !== 32'h5) begin n_fail++; $display("FAIL merge_mem_lo: got %h want %h", mem_lo_o, 32'h5); end
        n_checks++; if (wb_hi_o !== 32'h0) begin n_fail++; $display("FAIL merge_wb_hi: got %h want %h", wb_hi_o, 32'h0); end
        n_checks++; if (lo_o !== 32'hAAAA0000) begin n_fail++; $display("FAIL merge_lo_c2: got %h want %h", lo_o, 32'hAAAA0000); end
        tick(); tick();                                 // cycle 4
        n_checks++; if (hi_o !== 32'h7) begin n_fail++; $display("FAIL merge_final_hi: got %h want %h", hi_o, 32'h7); end
        n_checks++; if (lo_o !== 32'h5) begin n_fail++; $display("FAIL merge_final_lo: got %h want %h", lo_o, 32'h5); end
    endtask

    task automatic test_stall();
        // HI = 7, LO = 5 carried over from test_merge
        ex_req(1'b1, 1'b0, 32'h1, 32'h0);               // cycle 0
        tick(); idle(); stall_i = 3'b011;               // cycle 1
        n_checks++; if (mem_hi_o !== 32'h1) begin n_fail++; $display("FAIL stall_mem_hi_c1: got %h want %h", mem_hi_o, 32'h1); end
        tick();                                         // cycle 2
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL stall_wb_whilo_c2: got %b want 0", wb_whilo_o); end
        n_checks++; if (mem_whilo_o !== 1'b1) begin n_fail++; $display("FAIL stall_mem_whilo_c2: got %b want 1", mem_whilo_o); end
        tick(); stall_i = 3'b000;                       // cycle 3
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL stall_wb_whilo_c3: got %b want 0", wb_whilo_o); end
        n_checks++; if (mem_hi_o !== 32'h1) begin n_fail++; $display("FAIL stall_mem_hi_c3: got %h want %h", mem_hi_o, 32'h1); end
        n_checks++; if (hi_o !== 32'h7) begin n_fail++; $display("FAIL stall_hi_c3: got %h want %h", hi_o, 32'h7); end
        tick();                                         // cycle 4
        n_checks++; if (wb_whilo_o !== 1'b1) begin n_fail++; $display("FAIL stall_wb_whilo_c4: got %b want 1", wb_whilo_o); end
        n_checks++; if (mem_whilo_o !== 1'b0) begin n_fail++; $display("FAIL stall_mem_whilo_c4: got %b want 0", mem_whilo_o); end
        n_checks++; if (hi_o !== 32'h7) begin n_fail++; $display("FAIL stall_hi_c4: got %h want %h", hi_o, 32'h7); end
        tick();                                         // cycle 5
        n_checks++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL stall_hi_c5: got %h want %h", hi_o, 32'h1); end
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL stall_wb_whilo_c5: got %b want 0", wb_whilo_o); end
        n_checks++; if (lo_o !== 32'h5) begin n_fail++; $display("FAIL stall_lo_c5: got %h want %h", lo_o, 32'h5); end
    endtask

    task automatic test_flush();
        // HI = 1, LO = 5
        ex_req(1'b0, 1'b1, 32'h0, 32'h3);               // cycle 0: MTLO 3
        tick();
        ex_req(1'b1, 1'b0, 32'h9, 32'h0);               // cycle 1: MTHI 9
        tick(); idle(); flush_i = 1'b1;                 // cycle 2: flush
        tick(); flush_i = 1'b0;                         // cycle 3
        n_checks++; if (lo_o !== 32'h3) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo_o, 32'h3); end
        n_checks++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi_o, 32'h1); end
        n_checks++; if (mem_whilo_o !== 1'b0) begin n_fail++; $display("FAIL flush_mem_whilo: got %b want 0", mem_whilo_o); end
        n_checks++; if (wb_whilo_o !== 1'b0) begin n_fail++; $display("FAIL flush_wb_whilo: got %b want 0", wb_whilo_o); end
        n_checks++; if (mem_hi_o !== 32'h1) begin n_fail++; $display("FAIL flush_mem_hi: got %h want %h", mem_hi_o, 32'h1); end
        tick(); tick();                                 // cycle 5
        n_checks++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL flush_hi_late: got %h want %h", hi_o, 32'h1); end
    endtask

    task automatic test_both_halves();
        // HI = 1, LO = 3
        ex_req(1'b1, 1'b1, 32'hFFFF0000, 32'h0000FFFF); // cycle 0
        tick(); idle();                                 // cycle 1
        n_checks++; if (mem_hi_o !== 32'hFFFF0000) begin n_fail++; $display("FAIL both_mem_hi: got %h want %h", mem_hi_o, 32'hFFFF0000); end
        n_checks++; if (mem_lo_o !== 32'h0000FFFF) begin n_fail++; $display("FAIL both_mem_lo: got %h want %h", mem_lo_o, 32'h0000FFFF); end
        tick();                                         // cycle 2
        n_checks++; if (wb_lo_o !== 32'h0000FFFF) begin n_fail++; $display("FAIL both_wb_lo: got %h want %h", wb_lo_o, 32'h0000FFFF); end
        n_checks++; if (lo_o !== 32'h3) begin n_fail++; $display("FAIL both_lo_c2: got %h want %h", lo_o, 32'h3); end
        tick();                                         // cycle 3
        n_checks++; if (hi_o !== 32'hFFFF0000) begin n_fail++; $display("FAIL both_hi: got %h want %h", hi_o, 32'hFFFF0000); end
        n_checks++; if (lo_o !== 32'h0000FFFF) begin n_fail++; $display("FAIL both_lo: got %h want %h", lo_o, 32'h0000FFFF); end
    endtask

    task automatic test_back_to_back();
        // HI = FFFF0000
        ex_req(1'b1, 1'b0, 32'h11, 32'h0);              // cycle 0
        tick();
        ex_req(1'b1, 1'b0, 32'h22, 32'h0);              // cycle 1
        tick(); idle();                                 // cycle 2
        n_checks++; if (mem_hi_o !== 32'h22) begin n_fail++; $display("FAIL b2b_mem_hi: got %h want %h", mem_hi_o, 32'h22); end
        n_checks++; if (wb_hi_o !== 32'h11) begin n_fail++; $display("FAIL b2b_wb_hi: got %h want %h", wb_hi_o, 32'h11); end
        tick();                                         // cycle 3
        n_checks++; if (hi_o !== 32'h11) begin n_fail++; $display("FAIL b2b_hi_c3: got %h want %h", hi_o, 32'h11); end
        tick();                                         // cycle 4
        n_checks++; if (hi_o !== 32'h22) begin n_fail++; $display("FAIL b2b_hi_c4: got %h want %h", hi_o, 32'h22); end
    endtask

    task automatic test_reset_midstream();
        ex_req(1'b1, 1'b0, 32'hAA, 32'h0);              // cycle 0
        tick();
        ex_req(1'b0, 1'b1, 32'h0, 32'hBB);              // cycle 1
        tick(); idle(); rst = 1'b1;                     // cycle 2: both latches full
        n_checks++; if ((mem_whilo_o & wb_whilo_o) !== 1'b1) begin n_fail++; $display("FAIL rstmid_latches_full: got %b %b want 1 1", mem_whilo_o, wb_whilo_o); end
        tick(); rst = 1'b0;                             // cycle 3
        n_checks++; if ({hi_o, lo_o} !== 64'h0) begin n_fail++; $display("FAIL rstmid_arch: got %h %h want 0 0", hi_o, lo_o); end
        n_checks++; if ({mem_whilo_o, wb_whilo_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_whilo: got %b %b want 0 0", mem_whilo_o, wb_whilo_o); end
        n_checks++; if ({mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o} !== 128'h0) begin n_fail++; $display("FAIL rstmid_fwd: got %h %h %h %h want all 0", mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o); end
        tick(); tick();                                 // cycle 5
        n_checks++; if ({hi_o, lo_o} !== 64'h0) begin n_fail++; $display("FAIL rstmid_no_commit: got %h %h want 0 0", hi_o, lo_o); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        test_reset();
        test_single_mthi();
        test_merge();
        test_stall();
        test_flush();
        test_both_halves();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_pipe.md
Name: hilo_pipe

Overview:
- Write-side counterpart of the execute stage's HI/LO interface. It owns the architectural HI and LO registers.
- It carries each EX-stage HI/LO write request through the EX/MEM and MEM/WB pipeline latches and commits it at write-back.
- Every cycle it returns to EX the latched MEM-stage and WB-stage requests plus the committed register values, so EX can forward the newest HI/LO without stalling.
- Per-half write enables let MTHI and MTLO each leave the other register untouched.

Parameters:
- DW, 32, data width of HI and LO.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  3  stall vector; bit0 EX, bit1 MEM, bit2 WB; monotonic (bit k set implies bit k-1 set)
- flush_i  in  1  pipeline flush (exception/eret); drops uncommitted requests
- ex_whi_i  in  1  EX instruction writes HI
- ex_wlo_i  in  1  EX instruction writes LO
- ex_hi_i  in  DW  HI write data from EX
- ex_lo_i  in  DW  LO write data from EX
- mem_whilo_o  out  1  MEM-stage latch holds a HI or LO write
- mem_hi_o  out  DW  HI as seen after the MEM-stage request
- mem_lo_o  out  DW  LO as seen after the MEM-stage request
- wb_whilo_o  out  1  WB-stage latch holds a HI or LO write
- wb_hi_o  out  DW  HI as seen after the WB-stage request
- wb_lo_o  out  DW  LO as seen after the WB-stage request
- hi_o  out  DW  architectural HI
- lo_o  out  DW  architectural LO

Behaviour:
- State:
  - EX/MEM latch {m_whi, m_wlo, m_hi, m_lo}
  - MEM/WB latch {w_whi, w_wlo, w_hi, w_lo}
  - registers HI, LO
- Reset (rst=1 at edge): all latch enables and data become 0; HI=LO=0. Consequently every output is 0 in the following cycle. rst has priority over flush_i and stall_i.
- EX/MEM latch, priority order:
  - flush_i: clear to 0.
  - stall_i[1]: hold.
  - stall_i[0] and !stall_i[1]: load bubble (enables 0, data 0).
  - else: load the ex_* inputs.
- MEM/WB latch, priority order:
  - flush_i: clear to 0.
  - stall_i[2]: hold.
  - stall_i[1] and !stall_i[2]: load bubble.
  - else: load the EX/MEM latch contents.
- Commit: when !stall_i[2], HI<=w_hi if w_whi and LO<=w_lo if w_wlo. A disabled half is never modified.
  - Commit also occurs on a flush edge, because the WB instruction is already retired.
  - While the WB stage is held, no commit occurs and the latch is retained, so the write commits exactly once.
- Latency: an EX request at cycle n appears on mem_* in cycle n+1 and on wb_* in cycle n+2. It commits at the n+3 edge, so hi_o/lo_o show it from cycle n+3. Stalls extend this cycle-for-cycle.
- Forwarding outputs are combinational from state and must be merged per half, so that a consumer selecting "MEM, else WB, else register" as a whole word gets the correct value:
  - wb_hi_o = w_whi ? w_hi : HI; wb_lo_o = w_wlo ? w_lo : LO.
  - mem_hi_o = m_whi ? m_hi : wb_hi_o; mem_lo_o = m_wlo ? m_lo : wb_lo_o.
  - mem_whilo_o = m_whi|m_wlo; wb_whilo_o = w_whi|w_wlo.
- Both halves are written when ex_whi_i and ex_wlo_i are both set (reserved for mult/div results).
- A non-monotonic stall_i is illegal; behaviour is unspecified and flagged by a simulation assertion.
- Back-to-back writes to the same half resolve youngest-first via the merge rules above.

Test Plan:
- Reset then a single MTHI (ex_whi_i=1, ex_hi_i=0x12345678) at cycle 0 → mem_whilo_o=1 and mem_hi_o=0x12345678 at cycle 1; wb_hi_o=0x12345678 at cycle 2; hi_o=0x12345678 from cycle 3; lo_o stays 0 throughout.
- With HI=0, LO=0xAAAA0000: MTLO 0x5 at cycle 0, MTHI 0x7 at cycle 1 → in cycle 2, mem_hi_o=0x7 and mem_lo_o=0x5 (LO merged from WB). Final state HI=0x7, LO=0x5.
- MTHI 0x1 at cycle 0 with stall_i=3'b011 held for cycles 1–2, then 3'b000 → request held in EX/MEM and MEM/WB receives a bubble during the stall; wb_whilo_o=0 in cycles 2–3; commit exactly once, and hi_o=0x1 two cycles after release.
- flush_i in the cycle after MTHI 0x9 (request in EX/MEM), with an older MTLO 0x3 in MEM/WB → LO=0x3 committed, HI unchanged, both latches cleared, mem_whilo_o=wb_whilo_o=0 next cycle.
- Simultaneous ex_whi_i=ex_wlo_i=1 with data 0xFFFF0000/0x0000FFFF → both committed at the n+3 edge.
- Assert rst mid-stream with requests in both latches → all outputs 0 the next cycle, and nothing commits.
